// File: rtl/harp_pkg.sv
// rtl/harp_pkg.sv - shared constants and state types for the HARP timestamp receiver
package harp_pkg;
  localparam logic [7:0] HARP_HDR0     = 8'hAA;
  localparam logic [7:0] HARP_HDR1     = 8'hAF;
  localparam int         HARP_TS_BYTES = 4;

  typedef enum logic [1:0] {HUNT_AA, HUNT_AF, TS, WAIT_SEC} parser_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 2-flop synchronizer plus 8N1 byte receiver with glitch rejection
module uart_rx_byte
  import harp_pkg::*;
#(
  parameter int BIT_CYC = 600
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_err,
  output logic       o_start_det
);
  localparam int               CNT_W     = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);

  logic             r_rx_meta, r_rx_s;
  rx_state_t        r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_cnt_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // The start bit is re-checked at half a bit period; data and stop are sampled mid-bit.
  assign w_cnt_done = (r_state == RX_START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= RX_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:      if (!r_rx_s) w_next = RX_START;
      RX_START:     if (w_cnt_done) w_next = r_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_cnt_done && r_bit_idx == 3'd7) w_next = RX_STOP;
      RX_STOP:      if (w_cnt_done) w_next = r_rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (r_rx_s) w_next = RX_IDLE;
      default:      w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    o_start_det  = (r_state == RX_IDLE) && !r_rx_s;
    o_byte_valid = (r_state == RX_STOP) && w_cnt_done && r_rx_s;
    o_byte_err   = (r_state == RX_STOP) && w_cnt_done && !r_rx_s;
    o_byte_data  = r_shift;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == RX_IDLE || r_state == RX_WAIT_HIGH || w_cnt_done) r_cnt <= '0;
      else                                                             r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_DATA && w_cnt_done) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/harp_sync_rx.sv
// rtl/harp_sync_rx.sv - HARP timestamp parser, second-boundary strobe and lock tracking
module harp_sync_rx
  import harp_pkg::*;
#(
  parameter int CLK_RATE_HZ    = 60_000_000,
  parameter int BAUD_HZ        = 100_000,
  parameter int SEC_OFFSET_CYC = 40_320,
  parameter int BYTE_GAP_BITS  = 20,
  parameter int LOCK_LOSS_CYC  = 120_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx,
  output logic [31:0] o_seconds,
  output logic        o_sec_strobe,
  output logic        o_locked,
  output logic        o_frame_err
);
  localparam int BIT_CYC = CLK_RATE_HZ / BAUD_HZ;
  localparam int GAP_CYC = BYTE_GAP_BITS * BIT_CYC;
  localparam int SEC_W   = $clog2(SEC_OFFSET_CYC);
  localparam int GAP_W   = $clog2(GAP_CYC);
  localparam int LOCK_W  = $clog2(LOCK_LOSS_CYC);

  logic               w_byte_valid, w_byte_err, w_start_det;
  logic [7:0]         w_byte_data;
  parser_state_t      r_state, w_next_state;
  logic [31:0]        r_ts;
  logic [1:0]         r_ts_idx;
  logic [SEC_W-1:0]   r_sec_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic               w_in_frame, w_gap_timeout, w_err_evt, w_strobe_evt;

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_byte_err   (w_byte_err),
    .o_start_det  (w_start_det)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= HUNT_AA;
    else         r_state <= w_next_state;
  end

  // A byte arriving in the timeout cycle suppresses the timeout.
  always_comb begin
    w_in_frame    = (r_state == HUNT_AF) || (r_state == TS);
    w_gap_timeout = w_in_frame && (r_gap_cnt == GAP_W'(GAP_CYC - 1)) && !w_byte_valid;
    w_err_evt     = w_byte_err || w_gap_timeout || ((r_state == WAIT_SEC) && w_start_det);
    w_strobe_evt  = (r_state == WAIT_SEC) && (r_sec_cnt == '0) && !w_err_evt;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_err_evt) begin
      w_next_state = HUNT_AA;
    end else begin
      case (r_state)
        HUNT_AA:  if (w_byte_valid && w_byte_data == HARP_HDR0) w_next_state = HUNT_AF;
        HUNT_AF:  if (w_byte_valid) begin
                    if (w_byte_data == HARP_HDR1)      w_next_state = TS;
                    else if (w_byte_data != HARP_HDR0) w_next_state = HUNT_AA;
                  end
        TS:       if (w_byte_valid && r_ts_idx == 2'(HARP_TS_BYTES - 1)) w_next_state = WAIT_SEC;
        WAIT_SEC: if (r_sec_cnt == '0) w_next_state = HUNT_AA;
        default:  w_next_state = HUNT_AA;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ts         <= '0;
      r_ts_idx     <= '0;
      r_sec_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_lock_cnt   <= '0;
      o_seconds    <= '0;
      o_sec_strobe <= 1'b0;
      o_locked     <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      if (r_state == HUNT_AF && w_next_state == TS) r_ts_idx <= '0;
      else if (r_state == TS && w_byte_valid) begin
        r_ts[{r_ts_idx, 3'b000} +: 8] <= w_byte_data;
        r_ts_idx                      <= r_ts_idx + 1'b1;
      end
      if (r_state == TS && w_next_state == WAIT_SEC)       r_sec_cnt <= SEC_W'(SEC_OFFSET_CYC - 1);
      else if (r_state == WAIT_SEC && r_sec_cnt != '0)     r_sec_cnt <= r_sec_cnt - 1'b1;
      if (!w_in_frame || w_byte_valid) r_gap_cnt <= '0;
      else                             r_gap_cnt <= r_gap_cnt + 1'b1;
      o_sec_strobe <= w_strobe_evt;
      o_frame_err  <= w_err_evt;
      if (w_strobe_evt) begin
        o_seconds  <= r_ts + 32'd1;
        o_locked   <= 1'b1;
        r_lock_cnt <= '0;
      end else if (o_locked) begin
        if (r_lock_cnt == LOCK_W'(LOCK_LOSS_CYC - 1)) begin
          o_locked   <= 1'b0;
          r_lock_cnt <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_harp_sync_rx.sv
// tb/tb_harp_sync_rx.sv - randomized self-checking bench for harp_sync_rx
module tb_harp_sync_rx;
  localparam int CLK_HZ    = 1_600_000;
  localparam int BAUD      = 100_000;
  localparam int B         = CLK_HZ / BAUD;
  localparam int OFF       = 200;
  localparam int GAP_BITS  = 20;
  localparam int LOCK      = 4000;
  // falling edge of start bit -> strobe: 2 sync flops, half bit, 9 bits to stop sample, offset
  localparam int LAT       = 2 + B / 2 + 9 * B + OFF;

  typedef logic [8:0] rxb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] seconds;
  logic        sec_strobe, locked, frame_err;

  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  int          n_strobe = 0, n_ferr = 0;
  int          last_t0 = 0, last_strobe_cyc = -1, lock_fall_cyc = -1;
  logic        prev_locked = 1'b0;
  logic [31:0] exp_seconds = 32'd0;

  always #5 clk = ~clk;

  harp_sync_rx #(
    .CLK_RATE_HZ    (CLK_HZ),
    .BAUD_HZ        (BAUD),
    .SEC_OFFSET_CYC (OFF),
    .BYTE_GAP_BITS  (GAP_BITS),
    .LOCK_LOSS_CYC  (LOCK)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx         (rx),
    .o_seconds    (seconds),
    .o_sec_strobe (sec_strobe),
    .o_locked     (locked),
    .o_frame_err  (frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sec_strobe) begin
      n_strobe        = n_strobe + 1;
      last_strobe_cyc = cyc;
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (prev_locked && !locked && !rst) lock_fall_cyc = cyc;
    prev_locked = locked;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    last_t0 = cyc + 1;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    rx = stop_ok;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(0, 2 * B)) @(negedge clk);
  endtask

  // Protocol-level model: any bad stop bit is one error; otherwise the first AA AF
  // followed by four bytes is the little-endian timestamp.
  function automatic bit model_frame(input rxb_t q[$], output logic [31:0] ts);
    ts = 32'd0;
    foreach (q[i]) if (!q[i][8]) return 1'b0;
    for (int i = 0; i + 5 < q.size(); i++)
      if (q[i][7:0] == 8'hAA && q[i+1][7:0] == 8'hAF) begin
        ts = {q[i+5][7:0], q[i+4][7:0], q[i+3][7:0], q[i+2][7:0]};
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic run_frame(input string tag, input rxb_t q[$]);
    int          s0, e0;
    bit          ok, bad;
    logic [31:0] ts;
    s0 = n_strobe;
    e0 = n_ferr;
    bad = 1'b0;
    foreach (q[i]) begin
      if (!q[i][8]) bad = 1'b1;
      send_byte(q[i][7:0], q[i][8]);
    end
    ok = model_frame(q, ts);
    repeat (OFF + 40) @(negedge clk);
    if (ok) begin
      exp_seconds = ts + 32'd1;
      check({tag, "_strobes"}, 32'(n_strobe - s0), 32'd1);
      check({tag, "_strobe_time"}, 32'(last_strobe_cyc), 32'(last_t0 + LAT));
      check({tag, "_locked"}, 32'(locked), 32'd1);
    end else begin
      check({tag, "_strobes"}, 32'(n_strobe - s0), 32'd0);
    end
    check({tag, "_errs"}, 32'(n_ferr - e0), bad ? 32'd1 : 32'd0);
    check({tag, "_seconds"}, seconds, exp_seconds);
  endtask

  initial begin
    rxb_t        q[$];
    logic [31:0] ts;
    logic [7:0]  b;
    int          s0, e0, pos;
    bit          bad;

    repeat (3) @(negedge clk);
    check("rst_seconds", seconds, 32'd0);
    check("rst_strobe", 32'(sec_strobe), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame("nominal", '{9'h1AA, 9'h1AF, 9'h110, 9'h100, 9'h100, 9'h100});
    check("nominal_value", seconds, 32'h11);
    run_frame("wrap", '{9'h1AA, 9'h1AF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF});
    check("wrap_value", seconds, 32'h0);

    run_frame("badstop", '{9'h1AA, 9'h1AF, 9'h122, 9'h133, 9'h044});
    run_frame("after_bad", '{9'h1AA, 9'h1AF, 9'h105, 9'h100, 9'h100, 9'h100});
    check("after_bad_value", seconds, 32'h6);

    run_frame("hdr_recover", '{9'h155, 9'h1AA, 9'h1AA, 9'h1AF, 9'h101, 9'h100, 9'h100, 9'h100});
    check("hdr_recover_value", seconds, 32'h2);

    for (int it = 0; it < 6; it++) begin
      q.delete();
      ts  = $urandom;
      bad = ($urandom_range(0, 2) == 0);
      pos = $urandom_range(0, 3);
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hAA);
        q.push_back({1'b1, b});
      end
      q.push_back(9'h1AA);
      q.push_back(9'h1AF);
      for (int k = 0; k < 4; k++) begin
        if (bad && k == pos) begin
          q.push_back({1'b0, ts[8*k +: 8]});
          break;
        end
        q.push_back({1'b1, ts[8*k +: 8]});
      end
      run_frame($sformatf("rand%0d", it), q);
    end

    s0 = n_strobe;
    e0 = n_ferr;
    @(negedge clk);
    rx = 1'b0;
    repeat (B / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("glitch_errs", 32'(n_ferr - e0), 32'd0);
    check("glitch_strobes", 32'(n_strobe - s0), 32'd0);

    e0 = n_ferr;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAF, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (3 * GAP_BITS * B) @(negedge clk);
    check("gap_errs", 32'(n_ferr - e0), 32'd1);
    run_frame("after_gap", '{9'h1AA, 9'h1AF, 9'h1C8, 9'h100, 9'h100, 9'h100});

    s0 = n_strobe;
    e0 = n_ferr;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAF, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'h07, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (OFF + 40) @(negedge clk);
    check("overlap_errs", 32'(n_ferr - e0), 32'd1);
    check("overlap_strobes", 32'(n_strobe - s0), 32'd0);
    check("overlap_seconds", seconds, exp_seconds);

    run_frame("pre_lock", '{9'h1AA, 9'h1AF, 9'h140, 9'h130, 9'h120, 9'h110});
    lock_fall_cyc = -1;
    repeat (LOCK) @(negedge clk);
    check("lock_fall_time", 32'(lock_fall_cyc), 32'(last_strobe_cyc + LOCK));
    check("lock_lost", 32'(locked), 32'd0);
    check("lock_hold_seconds", seconds, exp_seconds);

    run_frame("pre_reset", '{9'h1AA, 9'h1AF, 9'h109, 9'h100, 9'h100, 9'h100});
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAF, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'h33, 1'b1);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_seconds", seconds, 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_strobe", 32'(sec_strobe), 32'd0);
    s0 = n_strobe;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (OFF + 50) @(negedge clk);
    check("post_rst_strobes", 32'(n_strobe - s0), 32'd0);
    check("post_rst_seconds", seconds, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
